eth_rx_fsm: RTL
===============

Name: eth_rx_fsm

Overview:
Byte-domain Ethernet receive framer, the counterpart of the transmit FSM. It consumes one byte per i_eth_clk from the RGMII DDR capture front-end and hunts for the preamble and SFD. It parses and filters the destination MAC, latches the source MAC, writes EtherType, payload and FCS into the RX frame memory, and checks CRC-32. On frame end it reports length and status to the host/loopback logic.

Parameters:
ADDR_W, 16, RX memory address width; also the width of o_frame_len
MAX_BYTES, 1536, maximum bytes written per frame (EtherType through FCS); exceeding this drops the frame
MIN_FRAME, 64, minimum destination-MAC-through-FCS byte count; shorter frames are runts
FILTER_EN, 1, 1 = accept only broadcast or LOCAL_MAC destinations; 0 = promiscuous
LOCAL_MAC, 48'h1A_2B_3C_4D_5E_6F, station address

Ports:
i_eth_clk  in  1  receive byte clock
i_rst  in  1  synchronous reset, active-high
i_rx_dv  in  1  byte valid (RX_CTL rising-edge half)
i_rx_er  in  1  PHY error (RX_CTL XOR of both halves)
i_rx_data  in  8  received byte, LSB nibble first on the wire
o_mem_wr_en  out  1  RX memory write strobe
o_mem_wr_addr  out  ADDR_W  write address, 0 = first EtherType byte
o_mem_wr_data  out  8  write data
o_frame_good  out  1  one-cycle pulse: frame accepted, CRC ok
o_frame_bad  out  1  one-cycle pulse: frame accepted by filter but CRC error or runt
o_runt  out  1  qualifies o_frame_bad; valid with the pulse
o_frame_len  out  ADDR_W  bytes written minus 4 (FCS excluded); valid with the pulses
o_mac_src  out  48  source MAC of the last reported frame
o_drop_count  out  16  saturating count of dropped frames
o_busy  out  1  high from the cycle after SFD until the frame is reported or dropped

Behaviour:
- Reset: i_rst synchronous, active-high, clock i_eth_clk. All outputs 0; state IDLE; CRC register 32'hFFFFFFFF; armed flag 0.
- Armed flag: set once i_rx_dv=0 has been sampled after reset. While armed=0, IDLE ignores input, so a reset released mid-frame never captures the frame tail.
- IDLE: when armed and dv=1 and data=8'h55, go to PREAMBLE. dv=1 with any other byte goes to DROP.
- PREAMBLE: 8'h55 stays; 8'hD5 goes to MAC_DES with CRC init and cnt=0; any other byte, or dv=0, goes to DROP. At least one 8'h55 is required. No upper bound on preamble length.
- MAC_DES: 6 bytes, shifted MSB-first into a 48-bit register (first byte = [47:40]).
- On the 6th destination byte, evaluate the filter. If FILTER_EN and dest is neither all-ones nor LOCAL_MAC, go to DROP. Otherwise go to MAC_SRC.
- MAC_SRC: 6 bytes into a shadow register. Then go to PAYLOAD with wr_addr=0.
- PAYLOAD: each dv=1 byte is written. o_mem_wr_* is registered, so write latency is 1 cycle after the byte is sampled. wr_addr increments by 1.
- PAYLOAD overflow: if a byte arrives with wr_addr = MAX_BYTES, go to DROP with no write.
- End of frame: the edge that samples dv=0 in PAYLOAD drives exactly one of o_frame_good or o_frame_bad for one cycle, along with o_frame_len, o_runt, and o_mac_src (copied from the shadow register). State returns to IDLE in the same edge.
- CRC: reflected polynomial 32'hEDB88320, LSB-first per byte. Update covers every byte from the first destination byte through the last FCS byte. No final inversion. Good iff register = 32'hDEBB20E3 at the dv=0 edge.
- Runt: total count (12 + bytes written) < MIN_FRAME gives o_frame_bad with o_runt=1, regardless of CRC.
- Short frames: bytes written < 4 is always a runt. In this case o_frame_len = 0, saturated and not negative.
- i_rx_er=1 with dv=1 in any state other than IDLE/DROP goes to DROP. Bytes already written are abandoned.
- DROP: no writes. Wait for a dv=0 sample, then go to IDLE. o_drop_count increments once per entry to DROP and saturates at 16'hFFFF. A filter miss counts as a drop. Dropped frames produce no good/bad pulse.
- dv=0 mid-header (MAC_DES/MAC_SRC) goes to IDLE and is counted as a drop.
- There is no backpressure. Memory contents are valid until the next frame's first write; the consumer must drain it before then.
- Back-to-back frames: a new preamble is accepted on the cycle after the report edge. No minimum IPG is enforced.

Decomposition:
- Shared package eth_pkg: state encodings (shared with eth_tx_fsm), PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, BCAST_MAC, CRC_POLY, CRC_INIT, CRC_RESIDUE.
- One sub-module: eth_rx_crc32_chk. It is a byte-serial CRC-32 with init/enable inputs and a match output. It is separately testable against known vectors.

Test Plan:
- Broadcast frame: 7×55, D5, dest FF×6, src 1A2B3C4D5E6F, type 0800, 46 bytes 00..2D, correct FCS -> o_frame_good=1, o_frame_len=48, mem[0]=08, mem[2]=00, mem[47]=2D, o_mac_src=1A2B3C4D5E6F, o_drop_count=0.
- Same frame with the last FCS byte XOR 01 -> o_frame_bad=1, o_runt=0, o_frame_len=48, no o_frame_good.
- Dest 02:00:00:00:00:01 with FILTER_EN=1 -> no writes, no pulses, o_drop_count=1. Repeat with FILTER_EN=0 -> o_frame_good.
- Frame with 20-byte payload and valid FCS (total 38) -> o_frame_bad=1, o_runt=1, o_frame_len=22.
- i_rx_er pulsed on payload byte 10 -> o_drop_count=1, no pulses. A following valid frame gives o_frame_good.
- i_rst asserted for 2 cycles mid-payload and released while dv=1 -> nothing captured until dv falls. The next full frame gives o_frame_good with o_drop_count=0.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet framer constants, state encoding and CRC-32 byte step
//
// Purpose: constants and types used by both the receive and transmit framers.
//   eth_state_t     : framer state encoding (ST_FCS / ST_IPG are used by the transmit side only)
//   PREAMBLE_BYTE   : 8'h55
//   SFD_BYTE        : 8'hD5
//   BCAST_MAC       : all-ones destination
//   CRC_POLY        : reflected CRC-32 polynomial
//   CRC_INIT        : CRC register preset
//   CRC_RESIDUE     : register value after a frame plus its correct FCS (no final inversion)
//   crc32_byte()    : one byte of reflected CRC-32, LSB first
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_MAC_DES  = 3'd2,
        ST_MAC_SRC  = 3'd3,
        ST_PAYLOAD  = 3'd4,
        ST_FCS      = 3'd5,
        ST_IPG      = 3'd6,
        ST_DROP     = 3'd7
    } eth_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_crc32_chk.sv
// rtl/eth_rx_crc32_chk.sv - byte-serial CRC-32 checker with residue match
//
// Purpose: accumulates a reflected CRC-32 over a byte stream and flags when the
// register holds the good-frame residue.
// Ports:
//   i_eth_clk  in   byte clock
//   i_rst      in   synchronous reset, active-high (register preset to CRC_INIT)
//   i_init     in   preset register to CRC_INIT (wins over i_en)
//   i_en       in   fold i_data into the register
//   i_data     in   8-bit data byte, LSB processed first
//   o_match    out  register equals CRC_RESIDUE
module eth_rx_crc32_chk
    import eth_pkg::*;
(
    input  logic       i_eth_clk,
    input  logic       i_rst,
    input  logic       i_init,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic       o_match
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (i_init) begin
            crc_d = CRC_INIT;
        end else if (i_en) begin
            crc_d = crc32_byte(crc_q, i_data);
        end
    end

    always_ff @(posedge i_eth_clk) begin
        if (i_rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_match = (crc_q == CRC_RESIDUE);

endmodule

// File: rtl/eth_rx_fsm.sv
// rtl/eth_rx_fsm.sv - byte-domain Ethernet receive framer
//
// Purpose: hunts preamble/SFD, filters destination MAC, latches source MAC,
// writes EtherType..FCS into RX memory, checks CRC-32 and reports each frame.
// Ports:
//   i_eth_clk      in   receive byte clock
//   i_rst          in   synchronous reset, active-high
//   i_rx_dv        in   byte valid
//   i_rx_er        in   PHY error
//   i_rx_data      in   received byte
//   o_mem_wr_en    out  RX memory write strobe (one cycle after the byte is sampled)
//   o_mem_wr_addr  out  write address, 0 = first EtherType byte
//   o_mem_wr_data  out  write data
//   o_frame_good   out  pulse: frame passed filter, CRC ok, not a runt
//   o_frame_bad    out  pulse: frame passed filter, CRC error or runt
//   o_runt         out  qualifies o_frame_bad
//   o_frame_len    out  bytes written minus FCS, floored at 0
//   o_mac_src      out  source MAC of the last reported frame
//   o_drop_count   out  saturating dropped-frame count
//   o_busy         out  frame in progress after SFD
module eth_rx_fsm
    import eth_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int          MAX_BYTES = 1536,
    parameter int          MIN_FRAME = 64,
    parameter int          FILTER_EN = 1,
    parameter logic [47:0] LOCAL_MAC = 48'h1A_2B_3C_4D_5E_6F
) (
    input  logic              i_eth_clk,
    input  logic              i_rst,
    input  logic              i_rx_dv,
    input  logic              i_rx_er,
    input  logic [7:0]        i_rx_data,
    output logic              o_mem_wr_en,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [7:0]        o_mem_wr_data,
    output logic              o_frame_good,
    output logic              o_frame_bad,
    output logic              o_runt,
    output logic [ADDR_W-1:0] o_frame_len,
    output logic [47:0]       o_mac_src,
    output logic [15:0]       o_drop_count,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(MAX_BYTES);
    localparam logic [ADDR_W:0]   MIN_TOTAL = (ADDR_W+1)'(MIN_FRAME);
    // Destination + source MAC bytes, which are counted toward the runt limit but not written.
    localparam logic [ADDR_W:0]   HDR_BYTES = (ADDR_W+1)'(12);
    localparam logic [ADDR_W-1:0] FCS_BYTES = ADDR_W'(4);

    eth_state_t        state_q, state_d;
    logic              armed_q;
    logic [2:0]        cnt_q, cnt_d;
    logic [47:0]       dest_q, dest_d, dest_next;
    logic [47:0]       src_q, src_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic              mem_wr_en_q;
    logic [ADDR_W-1:0] mem_wr_addr_q;
    logic [7:0]        mem_wr_data_q;
    logic              frame_good_q;
    logic              frame_bad_q;
    logic              runt_q;
    logic [ADDR_W-1:0] frame_len_q;
    logic [47:0]       mac_src_q;
    logic [15:0]       drop_count_q;

    logic              crc_init;
    logic              crc_en;
    logic              crc_match;
    logic              wr_en_d;
    logic              report;
    logic              drop_evt;
    logic              runt_now;
    logic [ADDR_W:0]   total_bytes;
    logic [ADDR_W-1:0] len_now;
    logic              dest_ok;

    eth_rx_crc32_chk u_crc (
        .i_eth_clk (i_eth_clk),
        .i_rst     (i_rst),
        .i_init    (crc_init),
        .i_en      (crc_en),
        .i_data    (i_rx_data),
        .o_match   (crc_match)
    );

    // Frame-end classification, evaluated against the byte count so far.
    always_comb begin
        total_bytes = {1'b0, wr_addr_q} + HDR_BYTES;
        runt_now    = (total_bytes < MIN_TOTAL) || (wr_addr_q < FCS_BYTES);
        len_now     = (wr_addr_q < FCS_BYTES) ? '0 : (wr_addr_q - FCS_BYTES);
        dest_next   = {dest_q[39:0], i_rx_data};
        dest_ok     = (FILTER_EN == 0) || (dest_next == BCAST_MAC) || (dest_next == LOCAL_MAC);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dest_d    = dest_q;
        src_d     = src_q;
        wr_addr_d = wr_addr_q;
        crc_init  = 1'b0;
        crc_en    = 1'b0;
        wr_en_d   = 1'b0;
        report    = 1'b0;
        drop_evt  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Until a dv=0 has been seen after reset, a frame tail may be in flight.
                if (armed_q && i_rx_dv) begin
                    state_d = (i_rx_data == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!i_rx_dv || i_rx_er) begin
                    state_d = ST_DROP;
                end else if (i_rx_data == SFD_BYTE) begin
                    state_d  = ST_MAC_DES;
                    crc_init = 1'b1;
                    cnt_d    = '0;
                end else if (i_rx_data != PREAMBLE_BYTE) begin
                    state_d = ST_DROP;
                end
            end
            ST_MAC_DES: begin
                if (!i_rx_dv) begin
                    // Truncated header: straight to IDLE, still counted as a drop.
                    state_d  = ST_IDLE;
                    drop_evt = 1'b1;
                end else if (i_rx_er) begin
                    state_d = ST_DROP;
                end else begin
                    crc_en = 1'b1;
                    dest_d = dest_next;
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd5) begin
                        cnt_d   = '0;
                        state_d = dest_ok ? ST_MAC_SRC : ST_DROP;
                    end
                end
            end
            ST_MAC_SRC: begin
                if (!i_rx_dv) begin
                    state_d  = ST_IDLE;
                    drop_evt = 1'b1;
                end else if (i_rx_er) begin
                    state_d = ST_DROP;
                end else begin
                    crc_en = 1'b1;
                    src_d  = {src_q[39:0], i_rx_data};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd5) begin
                        cnt_d     = '0;
                        wr_addr_d = '0;
                        state_d   = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!i_rx_dv) begin
                    report  = 1'b1;
                    state_d = ST_IDLE;
                end else if (i_rx_er || (wr_addr_q == MAX_ADDR)) begin
                    state_d = ST_DROP;
                end else begin
                    crc_en    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                end
            end
            ST_DROP: begin
                if (!i_rx_dv) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_DROP) && (state_q != ST_DROP)) begin
            drop_evt = 1'b1;
        end
    end

    always_ff @(posedge i_eth_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            armed_q       <= 1'b0;
            cnt_q         <= '0;
            dest_q        <= '0;
            src_q         <= '0;
            wr_addr_q     <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            frame_good_q  <= 1'b0;
            frame_bad_q   <= 1'b0;
            runt_q        <= 1'b0;
            frame_len_q   <= '0;
            mac_src_q     <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_q | ~i_rx_dv;
            cnt_q       <= cnt_d;
            dest_q      <= dest_d;
            src_q       <= src_d;
            wr_addr_q   <= wr_addr_d;
            mem_wr_en_q <= wr_en_d;
            if (wr_en_d) begin
                mem_wr_addr_q <= wr_addr_q;
                mem_wr_data_q <= i_rx_data;
            end
            frame_good_q <= report && !runt_now && crc_match;
            frame_bad_q  <= report && (runt_now || !crc_match);
            runt_q       <= report && runt_now;
            if (report) begin
                frame_len_q <= len_now;
                mac_src_q   <= src_q;
            end
            if (drop_evt && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    assign o_mem_wr_en   = mem_wr_en_q;
    assign o_mem_wr_addr = mem_wr_addr_q;
    assign o_mem_wr_data = mem_wr_data_q;
    assign o_frame_good  = frame_good_q;
    assign o_frame_bad   = frame_bad_q;
    assign o_runt        = runt_q;
    assign o_frame_len   = frame_len_q;
    assign o_mac_src     = mac_src_q;
    assign o_drop_count  = drop_count_q;
    assign o_busy        = (state_q == ST_MAC_DES) || (state_q == ST_MAC_SRC) || (state_q == ST_PAYLOAD);

endmodule
